// File: rtl/ipm_sync_fifo_wl.sv
// rtl/ipm_sync_fifo_wl.sv - single-clock distributed-RAM FIFO, standard/FWFT read, over/underflow pulses
// Optional water_level output enabled by `define IPM_SYNC_FIFO_WATER_LEVEL_EN.
module ipm_sync_fifo_wl #(
  parameter int ADDR_WIDTH       = 9,
  parameter int DATA_WIDTH       = 8,
  parameter int FWFT             = 0,
  parameter int ALMOST_FULL_NUM  = 380,
  parameter int ALMOST_EMPTY_NUM = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  wr_en,
  output logic                  full,
  output logic                  almost_full,
  input  logic                  rd_en,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  empty,
  output logic                  almost_empty,
  output logic                  overflow,
  output logic                  underflow
`ifdef IPM_SYNC_FIFO_WATER_LEVEL_EN
  ,
  output logic [ADDR_WIDTH:0]   water_level
`endif
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] DEPTH_C = (ADDR_WIDTH + 1)'(DEPTH);
  localparam logic [ADDR_WIDTH:0] AF_C    = (ADDR_WIDTH + 1)'(ALMOST_FULL_NUM);
  localparam logic [ADDR_WIDTH:0] AE_C    = (ADDR_WIDTH + 1)'(ALMOST_EMPTY_NUM);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [ADDR_WIDTH-1:0] wr_ptr;
  logic [ADDR_WIDTH-1:0] rd_ptr;
  logic [ADDR_WIDTH:0]   count;
  logic [ADDR_WIDTH:0]   count_next;
  logic                  wr_ok;
  logic                  rd_ok;

  // Acceptance looks only at registered flags, so requests never reach the flags combinationally.
  assign wr_ok      = wr_en && !full;
  assign rd_ok      = rd_en && !empty;
  assign count_next = count + (ADDR_WIDTH + 1)'(wr_ok) - (ADDR_WIDTH + 1)'(rd_ok);

  always_ff @(posedge clk) begin
    if (wr_ok) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
      full         <= 1'b0;
      almost_full  <= 1'b0;
      empty        <= 1'b1;
      almost_empty <= 1'b1;
      overflow     <= 1'b0;
      underflow    <= 1'b0;
    end else begin
      if (wr_ok) wr_ptr <= wr_ptr + 1'b1;
      if (rd_ok) rd_ptr <= rd_ptr + 1'b1;
      count        <= count_next;
      full         <= (count_next == DEPTH_C);
      almost_full  <= (count_next >= AF_C);
      empty        <= (count_next == '0);
      almost_empty <= (count_next <= AE_C);
      overflow     <= wr_en && full;
      underflow    <= rd_en && empty;
    end
  end

  generate
    if (FWFT != 0) begin : g_fwft
      // Head word is shown directly; forced to zero while empty so reset reads back 0.
      assign rd_data = empty ? '0 : mem[rd_ptr];
    end else begin : g_std
      logic [DATA_WIDTH-1:0] rd_data_q;
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          rd_data_q <= '0;
        end else if (rd_ok) begin
          rd_data_q <= mem[rd_ptr];
        end
      end
      assign rd_data = rd_data_q;
    end
  endgenerate

`ifdef IPM_SYNC_FIFO_WATER_LEVEL_EN
  assign water_level = count;
`endif

endmodule
